// File: rtl/arbiter_types.sv
// Shared types for the instruction/data memory arbiter.
//   arb_state_t : FSM states (idle, serving I-side, serving D-side)
//   arb_grant_t : which side received the most recent grant
package arbiter_types;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_INST = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_INST = 1'b0,
        GRANT_DATA = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical-memory port between an instruction cache
// (read-only line fills) and a data cache (line fills and write-backs).
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   i_pmem_*            I-cache side: read request, address, rdata, resp
//   d_pmem_*            D-cache side: read/write request, address, wdata,
//                       rdata, resp
//   pmem_*              shared memory port: read/write command, address,
//                       wdata (all registered), rdata and resp from memory
//
// A grant latches the winner's address/operation/wdata, so the memory port is
// driven only from internal registers for the whole transaction. Every
// service returns through ARB_IDLE for one cycle, which gives the finished
// requester a chance to drop its request before the next arbitration.
module mem_arbiter
    import arbiter_types::*;
#(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,

    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,

    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t            state;
    arb_grant_t            last_grant;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic i_req, d_req, pick_inst;

    assign i_req = i_pmem_read;
    assign d_req = d_pmem_read | d_pmem_write;
    // On a tie the side that did not win last time is granted.
    assign pick_inst = i_req && (!d_req || last_grant == GRANT_DATA);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            last_grant <= GRANT_INST;
            addr_q     <= '0;
            wdata_q    <= '0;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_inst) begin
                        state      <= ARB_INST;
                        last_grant <= GRANT_INST;
                        addr_q     <= i_pmem_address;
                        pmem_read  <= 1'b1;
                        pmem_write <= 1'b0;
                    end else if (d_req) begin
                        state      <= ARB_DATA;
                        last_grant <= GRANT_DATA;
                        addr_q     <= d_pmem_address;
                        wdata_q    <= d_pmem_wdata;
                        // A simultaneous read+write performs the write only.
                        pmem_write <= d_pmem_write;
                        pmem_read  <= ~d_pmem_write;
                    end
                end
                ARB_INST, ARB_DATA: begin
                    if (pmem_resp) begin
                        state      <= ARB_IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= ARB_IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Responses are forwarded only to the side being served; a resp that
    // coincides with reset belongs to an abandoned transaction and is dropped.
    assign i_pmem_resp  = pmem_resp && (state == ARB_INST) && !reset;
    assign d_pmem_resp  = pmem_resp && (state == ARB_DATA) && !reset;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. Inputs change on the falling edge and
// outputs are checked 1 time unit later, so every check looks at the state
// settled after the preceding rising edge.
module tb_mem_arbiter;
    import arbiter_types::*;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          i_pmem_read;
    logic [AW-1:0] i_pmem_address;
    logic [LW-1:0] i_pmem_rdata;
    logic          i_pmem_resp;
    logic          d_pmem_read, d_pmem_write;
    logic [AW-1:0] d_pmem_address;
    logic [LW-1:0] d_pmem_wdata;
    logic [LW-1:0] d_pmem_rdata;
    logic          d_pmem_resp;
    logic          pmem_read, pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [LW-1:0] A5 = {32{8'hA5}};
    localparam logic [LW-1:0] W1 = {16{16'h1234}};
    localparam logic [LW-1:0] W2 = {32{8'h5A}};
    localparam logic [LW-1:0] W3 = {8{32'hDEADBEEF}};

    mem_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset),
        .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
        .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
        .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
        .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
        .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    // Check both response outputs together.
    task automatic chk_resp(input string tag, input logic ir, input logic dr);
        chk({tag, ".i_resp"}, LW'(i_pmem_resp), LW'(ir));
        chk({tag, ".d_resp"}, LW'(d_pmem_resp), LW'(dr));
    endtask

    task automatic chk_cmd(input string tag, input logic rd, input logic wr, input logic [AW-1:0] a);
        chk({tag, ".rd"},   LW'(pmem_read),    LW'(rd));
        chk({tag, ".wr"},   LW'(pmem_write),   LW'(wr));
        chk({tag, ".addr"}, LW'(pmem_address), LW'(a));
    endtask

    initial begin
        reset = 1'b1;
        i_pmem_read = 1'b0; i_pmem_address = '0;
        d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        d_pmem_address = '0; d_pmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;

        // ---- reset state; a resp during reset must not leak out
        cyc(); cyc();
        pmem_resp = 1'b1; #1;
        chk_cmd("rst", 1'b0, 1'b0, 32'h0);
        chk("rst.wdata", pmem_wdata, '0);
        chk_resp("rst", 1'b0, 1'b0);
        chk("rst.state", LW'(dut.state), LW'(ARB_IDLE));

        // ---- I-only read of 0x60, memory answers 5 cycles later
        cyc();
        reset = 1'b0; pmem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h0000_0060;
        #1 chk_cmd("i.idle", 1'b0, 1'b0, 32'h0);
        cyc(); #1;
        chk_cmd("i.c1", 1'b1, 1'b0, 32'h60);
        chk_resp("i.c1", 1'b0, 1'b0);
        cyc(); cyc(); cyc(); #1;
        chk_cmd("i.c4", 1'b1, 1'b0, 32'h60);
        cyc();
        pmem_resp = 1'b1; pmem_rdata = A5; i_pmem_read = 1'b0;
        #1 chk_resp("i.c5", 1'b1, 1'b0);
        chk("i.rdata", i_pmem_rdata, A5);
        chk("d.rdata_pass", d_pmem_rdata, A5);

        // ---- D write of 0x1000; requester wanders off mid-service
        cyc();
        pmem_resp = 1'b0;
        d_pmem_write = 1'b1; d_pmem_address = 32'h0000_1000; d_pmem_wdata = W1;
        #1 chk_cmd("i.done", 1'b0, 1'b0, 32'h60);
        chk_resp("i.done", 1'b0, 1'b0);
        cyc(); #1;
        chk_cmd("w.c1", 1'b0, 1'b1, 32'h1000);
        chk("w.c1.wdata", pmem_wdata, W1);
        d_pmem_address = 32'hFFFF_FFC0; d_pmem_wdata = W2;
        cyc(); #1;
        chk_cmd("w.c2", 1'b0, 1'b1, 32'h1000);
        chk("w.c2.wdata", pmem_wdata, W1);
        cyc();
        pmem_resp = 1'b1; d_pmem_write = 1'b0;
        #1 chk_resp("w.resp", 1'b0, 1'b1);
        cyc();
        pmem_resp = 1'b0;
        #1 chk("w.done.wr", LW'(pmem_write), LW'(1'b0));

        // ---- tie right after reset: D first, then I, then D on next tie
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h200;
        d_pmem_read = 1'b1; d_pmem_address = 32'h300;
        cyc(); #1;
        chk_cmd("t1.D", 1'b1, 1'b0, 32'h300);
        pmem_resp = 1'b1; d_pmem_read = 1'b0;
        #1 chk_resp("t1.D", 1'b0, 1'b1);
        cyc();
        pmem_resp = 1'b0;
        #1 chk_cmd("t1.idle", 1'b0, 1'b0, 32'h300);
        cyc(); #1;
        chk_cmd("t1.I", 1'b1, 1'b0, 32'h200);
        pmem_resp = 1'b1;
        #1 chk_resp("t1.I", 1'b1, 1'b0);
        cyc();
        pmem_resp = 1'b0;
        i_pmem_read = 1'b1; i_pmem_address = 32'h240;
        d_pmem_read = 1'b1; d_pmem_address = 32'h340;
        #1 chk_cmd("t2.idle", 1'b0, 1'b0, 32'h200);
        cyc(); #1;
        chk_cmd("t2.D", 1'b1, 1'b0, 32'h340);

        // ---- D keeps asking while I waits: D, I, D
        pmem_resp = 1'b1; d_pmem_address = 32'h380;
        #1 chk_resp("s.D1", 1'b0, 1'b1);
        cyc();
        pmem_resp = 1'b0;
        #1 chk_cmd("s.idle1", 1'b0, 1'b0, 32'h340);
        cyc(); #1;
        chk_cmd("s.I", 1'b1, 1'b0, 32'h240);
        pmem_resp = 1'b1; i_pmem_read = 1'b0;
        #1 chk_resp("s.I", 1'b1, 1'b0);
        cyc();
        pmem_resp = 1'b0;
        cyc(); #1;
        chk_cmd("s.D2", 1'b1, 1'b0, 32'h380);
        pmem_resp = 1'b1; d_pmem_read = 1'b0;
        #1 chk_resp("s.D2", 1'b0, 1'b1);

        // ---- reset during ARB_DATA with a coincident resp
        cyc();
        pmem_resp = 1'b0;
        d_pmem_write = 1'b1; d_pmem_address = 32'h500; d_pmem_wdata = W3;
        cyc(); #1;
        chk_cmd("r.busy", 1'b0, 1'b1, 32'h500);
        reset = 1'b1; pmem_resp = 1'b1;
        #1 chk_resp("r.rst", 1'b0, 1'b0);
        cyc();
        reset = 1'b0; pmem_resp = 1'b0;
        // read+write together must perform the write only
        d_pmem_read = 1'b1; d_pmem_write = 1'b1;
        d_pmem_address = 32'h700; d_pmem_wdata = W2;
        #1 chk_cmd("r.after", 1'b0, 1'b0, 32'h0);
        chk("r.after.state", LW'(dut.state), LW'(ARB_IDLE));
        chk("r.after.wdata", pmem_wdata, '0);

        // ---- read+write collision, then spurious resp in idle
        cyc(); #1;
        chk_cmd("rw", 1'b0, 1'b1, 32'h700);
        chk("rw.wdata", pmem_wdata, W2);
        pmem_resp = 1'b1; d_pmem_read = 1'b0; d_pmem_write = 1'b0;
        #1 chk_resp("rw", 1'b0, 1'b1);
        cyc();
        pmem_resp = 1'b0;
        cyc();
        pmem_resp = 1'b1;
        #1 chk_resp("spur", 1'b0, 1'b0);
        cyc();
        pmem_resp = 1'b0;
        #1 chk_cmd("spur.after", 1'b0, 1'b0, 32'h700);
        chk("spur.state", LW'(dut.state), LW'(ARB_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
